// File: rtl/ctl_pkg.sv
// ctl_pkg: constants shared between the control datapath and its input front end
package ctl_pkg;
  localparam int DEFAULT_DEBOUNCE_CYCLES = 4;
endpackage

// File: rtl/debounce_ch.sv
// debounce_ch: two-flop synchroniser, debounce counter and registered rising-edge pulse
module debounce_ch
  import ctl_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = DEFAULT_DEBOUNCE_CYCLES,
  parameter int CNT_W = $clog2(DEBOUNCE_CYCLES + 1)
) (
  input  logic clk,
  input  logic clear,
  input  logic raw,
  output logic level,
  output logic rise
);
  localparam logic [CNT_W-1:0] LAST = CNT_W'(DEBOUNCE_CYCLES - 1);
  logic sync1_q, sync2_q, stable_q, stable_d, rise_q, rise_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  // count consecutive disagreeing samples; adopt the new level on the last one
  always_comb begin
    stable_d = (sync2_q != stable_q && cnt_q == LAST) ? sync2_q : stable_q;
    cnt_d    = (sync2_q == stable_q || cnt_q == LAST) ? '0 : cnt_q + 1'b1;
    rise_d   = stable_d & ~stable_q;
  end
  // state registers, cleared asynchronously
  always_ff @(posedge clk or negedge clear) begin
    if (!clear) begin
      sync1_q  <= 1'b0;
      sync2_q  <= 1'b0;
      stable_q <= 1'b0;
      cnt_q    <= '0;
      rise_q   <= 1'b0;
    end else begin
      sync1_q  <= raw;
      sync2_q  <= sync1_q;
      stable_q <= stable_d;
      cnt_q    <= cnt_d;
      rise_q   <= rise_d;
    end
  end
  assign level = stable_q;
  assign rise  = rise_q;
endmodule

// File: rtl/input_conditioner.sv
// input_conditioner: synchronises and debounces raw start/qualify inputs into S pulse and X level
module input_conditioner
  import ctl_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = DEFAULT_DEBOUNCE_CYCLES,
  parameter int CNT_W = $clog2(DEBOUNCE_CYCLES + 1)
) (
  input  logic clk,
  input  logic clear,
  input  logic raw_start,
  input  logic raw_x,
  output logic S,
  output logic X,
  output logic start_level
);
  logic x_rise_unused;
  debounce_ch #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES), .CNT_W(CNT_W)) u_start (
    .clk(clk), .clear(clear), .raw(raw_start), .level(start_level), .rise(S)
  );
  debounce_ch #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES), .CNT_W(CNT_W)) u_x (
    .clk(clk), .clear(clear), .raw(raw_x), .level(X), .rise(x_rise_unused)
  );
endmodule

// File: tb/tb_input_conditioner.sv
// tb_input_conditioner: directed and randomized checks of the input conditioner
module tb_input_conditioner;
  localparam int D = 4;
  logic clk = 1'b0, clear = 1'b0, raw_start = 1'b0, raw_x = 1'b0;
  logic S, X, start_level;
  int n_tests = 0, n_fail = 0;

  always #5 clk = ~clk;

  input_conditioner #(.DEBOUNCE_CYCLES(D)) dut (
    .clk(clk), .clear(clear), .raw_start(raw_start), .raw_x(raw_x),
    .S(S), .X(X), .start_level(start_level)
  );

  // Reference: h[0] is the newest raw sample, h[i] the one i edges older.
  // A level flips when the last D synchronised samples all disagree with it.
  logic [D:0] hs, hx;
  logic m_lvl, m_x, m_s;

  function automatic logic flips(input logic [D:0] h, input logic lvl);
    return h[D:1] == {D{~lvl}};
  endfunction

  always @(posedge clk or negedge clear) begin
    if (!clear) begin
      hs <= '0; hx <= '0; m_lvl <= 1'b0; m_x <= 1'b0; m_s <= 1'b0;
    end else begin
      m_s   <= flips(hs, m_lvl) && !m_lvl;
      m_lvl <= flips(hs, m_lvl) ? ~m_lvl : m_lvl;
      m_x   <= flips(hx, m_x) ? ~m_x : m_x;
      hs    <= {hs[D-1:0], raw_start};
      hx    <= {hx[D-1:0], raw_x};
    end
  end

  task automatic tick();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic settle(input int n);
    for (int i = 0; i < n; i++) tick();
  endtask

  task automatic test_reset();
    clear = 1'b0; raw_start = 1'b1; raw_x = 1'b1;
    settle(3);
    n_tests++;
    if ({S, X, start_level} !== 3'b000) begin
      n_fail++; $display("FAIL reset_hold: S/X/lvl=%b expected 000", {S, X, start_level});
    end
    clear = 1'b1;
    for (int k = 1; k <= 12; k++) begin
      tick();
      n_tests++;
      if ({S, X, start_level} !== {k == 6, k >= 6, k >= 6}) begin
        n_fail++;
        $display("FAIL reset_release k=%0d: S/X/lvl=%b expected %b", k, {S, X, start_level},
                 {k == 6, k >= 6, k >= 6});
      end
    end
    raw_start = 1'b0; raw_x = 1'b0;
    settle(10);
  endtask

  task automatic test_bounce();
    for (int k = 0; k < 18; k++) begin
      raw_x = (k < 10) ? ~k[0] : 1'b0;
      tick();
      n_tests++;
      if (X !== 1'b0) begin
        n_fail++; $display("FAIL bounce k=%0d: X=%b expected 0", k, X);
      end
    end
  endtask

  task automatic test_clean_press();
    raw_start = 1'b1;
    for (int k = 1; k <= 20; k++) begin
      tick();
      n_tests++;
      if ({S, start_level} !== {k == 6, k >= 6}) begin
        n_fail++;
        $display("FAIL press k=%0d: S/lvl=%b expected %b", k, {S, start_level}, {k == 6, k >= 6});
      end
    end
    raw_start = 1'b0;
    for (int k = 1; k <= 10; k++) begin
      tick();
      n_tests++;
      if ({S, start_level} !== {1'b0, k < 6}) begin
        n_fail++;
        $display("FAIL release k=%0d: S/lvl=%b expected %b", k, {S, start_level}, {1'b0, k < 6});
      end
    end
  endtask

  task automatic test_threshold();
    for (int k = 1; k <= 12; k++) begin
      raw_x = (k <= 3);
      tick();
      n_tests++;
      if (X !== 1'b0) begin
        n_fail++; $display("FAIL short_pulse k=%0d: X=%b expected 0", k, X);
      end
    end
    for (int k = 1; k <= 16; k++) begin
      raw_x = (k <= 5);
      tick();
      n_tests++;
      if (X !== (k >= 6 && k <= 10)) begin
        n_fail++; $display("FAIL long_pulse k=%0d: X=%b expected %b", k, X, k >= 6 && k <= 10);
      end
    end
  endtask

  task automatic test_simultaneous();
    raw_start = 1'b1; raw_x = 1'b1;
    for (int k = 1; k <= 9; k++) begin
      tick();
      n_tests++;
      if ({S, X} !== {k == 6, k >= 6}) begin
        n_fail++; $display("FAIL simul k=%0d: S/X=%b expected %b", k, {S, X}, {k == 6, k >= 6});
      end
    end
    raw_start = 1'b0; raw_x = 1'b0;
    settle(10);
  endtask

  task automatic test_reset_mid();
    raw_x = 1'b1;
    settle(3);
    @(posedge clk);
    #2 clear = 1'b0;
    #1;
    n_tests++;
    if (X !== 1'b0) begin
      n_fail++; $display("FAIL mid_reset: X=%b expected 0", X);
    end
    @(negedge clk);
    clear = 1'b1;
    for (int k = 1; k <= 9; k++) begin
      tick();
      n_tests++;
      if (X !== (k >= 6)) begin
        n_fail++; $display("FAIL mid_reset_release k=%0d: X=%b expected %b", k, X, k >= 6);
      end
    end
    raw_x = 1'b0;
    settle(10);
  endtask

  task automatic test_s_reset();
    raw_start = 1'b1;
    settle(6);
    @(posedge clk);
    #2 clear = 1'b0;
    #1;
    n_tests++;
    if ({S, start_level} !== 2'b00) begin
      n_fail++; $display("FAIL s_reset: S/lvl=%b expected 00", {S, start_level});
    end
    raw_start = 1'b0;
    @(negedge clk);
    clear = 1'b1;
    for (int k = 1; k <= 10; k++) begin
      tick();
      n_tests++;
      if (S !== 1'b0) begin
        n_fail++; $display("FAIL s_no_replay k=%0d: S=%b expected 0", k, S);
      end
    end
  endtask

  task automatic test_random();
    int hold_s = 0, hold_x = 0;
    for (int c = 0; c < 3000; c++) begin
      if (hold_s == 0) begin raw_start = ~raw_start; hold_s = $urandom_range(1, 8); end
      if (hold_x == 0) begin raw_x = ~raw_x; hold_x = $urandom_range(1, 8); end
      hold_s--; hold_x--;
      if ($urandom_range(0, 299) == 0) begin
        clear = 1'b0; #1;
        n_tests++;
        if ({S, X, start_level} !== 3'b000) begin
          n_fail++; $display("FAIL rand_reset c=%0d: S/X/lvl=%b expected 000", c, {S, X, start_level});
        end
        #1 clear = 1'b1;
      end
      tick();
      n_tests++;
      if ({S, X, start_level} !== {m_s, m_x, m_lvl}) begin
        n_fail++;
        $display("FAIL random c=%0d: S/X/lvl=%b expected %b", c, {S, X, start_level}, {m_s, m_x, m_lvl});
      end
    end
  endtask

  initial begin
    test_reset();
    test_bounce();
    test_clean_press();
    test_threshold();
    test_simultaneous();
    test_reset_mid();
    test_s_reset();
    test_random();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
